// File: rtl/uart_rx_fifo_param.sv
// Oversampling UART receiver with parity/stop checking and a small receive FIFO.
// Optional UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote of the samples at counts c-2, c-1 and c.
module uart_rx_fifo_param #(
    parameter int WORD_SIZE   = 8,
    parameter int OVERSAMPLE  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 sampleClk,
    input  logic                 rst_b,
    input  logic                 serialIn,
    input  logic                 rxPop,
    output logic [WORD_SIZE-1:0] rxData,
    output logic                 rxValid,
    output logic                 rxBusy,
    output logic                 framingError,
    output logic                 parityError,
    output logic                 overrun
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WORD_SIZE + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_START     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_CENTRE    = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_LAST_BIT  = BW'(WORD_SIZE - 1);
    localparam logic          C_LAST_STOP = (STOP_BITS == 2);
    localparam logic          C_ODD       = (PARITY_MODE == 2);
    localparam logic [AW:0]   C_DEPTH     = (AW + 1)'(FIFO_DEPTH);

    // IDLE wait start | START confirm start | DATA shift | PARITY check | STOP check | WAIT_HIGH stuck-low line
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;

    state_t                r_state, w_next;
    logic                  r_sync1, r_sync2, w_line, w_bit;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bitcnt;
    logic                  r_stopcnt;
    logic [WORD_SIZE-1:0]  r_shift;
    logic                  r_par_err, r_fe, r_pe, r_ov;
    logic                  w_shift_en, w_par_load, w_stop_inc, w_fe_set, w_pe_set, w_push;
    logic                  w_pop, w_full, w_wr_en, w_ov_set;
    logic [WORD_SIZE-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr, r_rd;
    logic [AW:0]           r_count;

    assign w_line = r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic r_h1, r_h2;
    always_ff @(posedge sampleClk or negedge rst_b) begin
        if (!rst_b) begin
            r_h1 <= 1'b1;
            r_h2 <= 1'b1;
        end else begin
            r_h1 <= w_line;
            r_h2 <= r_h1;
        end
    end
    assign w_bit = (r_h1 & r_h2) | (r_h1 & w_line) | (r_h2 & w_line);
`else
    assign w_bit = w_line;
`endif

    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_par_load = 1'b0;
        w_stop_inc = 1'b0;
        w_fe_set   = 1'b0;
        w_pe_set   = 1'b0;
        w_push     = 1'b0;
        case (r_state)
            S_IDLE:   if (!w_line) w_next = S_START;
            S_START:  if (r_cnt == C_START) w_next = w_bit ? S_IDLE : S_DATA;
            S_DATA: begin
                if (r_cnt == C_CENTRE) begin
                    w_shift_en = 1'b1;
                    if (r_bitcnt == C_LAST_BIT) w_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (r_cnt == C_CENTRE) begin
                    w_par_load = 1'b1;
                    w_next     = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == C_CENTRE) begin
                    if (!w_bit) begin
                        w_fe_set = 1'b1;
                        w_next   = S_WAIT_HIGH;
                    end else if (r_stopcnt == C_LAST_STOP) begin
                        w_pe_set = r_par_err;
                        w_push   = !r_par_err;
                        w_next   = S_IDLE;
                    end else begin
                        w_stop_inc = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: if (w_line) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sampleClk or negedge rst_b) begin
        if (!rst_b) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_fe      <= 1'b0;
            r_pe      <= 1'b0;
        end else begin
            r_sync1 <= serialIn;
            r_sync2 <= r_sync1;
            r_state <= w_next;
            if (w_next != r_state || r_cnt == C_CENTRE) r_cnt <= '0;
            else                                        r_cnt <= r_cnt + 1'b1;
            if (r_state == S_IDLE) r_bitcnt <= '0;
            else if (w_shift_en)   r_bitcnt <= r_bitcnt + 1'b1;
            if (r_state != S_STOP) r_stopcnt <= 1'b0;
            else if (w_stop_inc)   r_stopcnt <= 1'b1;
            if (w_shift_en) r_shift <= {w_bit, r_shift[WORD_SIZE-1:1]};
            // Word parity plus received parity bit is even for even mode, odd for odd mode.
            if (r_state == S_IDLE) r_par_err <= 1'b0;
            else if (w_par_load)   r_par_err <= (^r_shift) ^ w_bit ^ C_ODD;
            r_fe <= w_fe_set;
            r_pe <= w_pe_set;
        end
    end

    assign w_pop    = rxPop && (r_count != '0);
    assign w_full   = (r_count == C_DEPTH);
    assign w_wr_en  = w_push && (!w_full || w_pop);
    assign w_ov_set = w_push && w_full && !w_pop;

    always_ff @(posedge sampleClk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ov    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr] <= r_shift;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_ov <= w_ov_set;
        end
    end

    assign rxData       = r_mem[r_rd];
    assign rxValid      = (r_count != '0);
    assign rxBusy       = (r_state != S_IDLE);
    assign framingError = r_fe;
    assign parityError  = r_pe;
    assign overrun      = r_ov;
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: an 8N1 instance and an 8E1 instance, checked against a queue model.
module tb_uart_rx_fifo_param;
    localparam int OS = 8, W = 8, DEPTH = 4;

    logic sampleClk = 1'b0, rst_b = 1'b0;
    logic ser0 = 1'b1, ser1 = 1'b1, pop0 = 1'b0, pop1 = 1'b0;
    logic [W-1:0] data0, data1;
    logic valid0, valid1, busy0, busy1, fe0, fe1, pe0, pe1, ov0, ov1;

    always #5 sampleClk = ~sampleClk;

    uart_rx_fifo_param #(.WORD_SIZE(W), .OVERSAMPLE(OS), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut0 (
        .sampleClk(sampleClk), .rst_b(rst_b), .serialIn(ser0), .rxPop(pop0), .rxData(data0), .rxValid(valid0),
        .rxBusy(busy0), .framingError(fe0), .parityError(pe0), .overrun(ov0));
    uart_rx_fifo_param #(.WORD_SIZE(W), .OVERSAMPLE(OS), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .sampleClk(sampleClk), .rst_b(rst_b), .serialIn(ser1), .rxPop(pop1), .rxData(data1), .rxValid(valid1),
        .rxBusy(busy1), .framingError(fe1), .parityError(pe1), .overrun(ov1));

    int n_vec = 0, n_err = 0;
    int nfe[2], npe[2], nov[2];
    logic [W-1:0] q0[$], q1[$];

    initial for (int i = 0; i < 2; i++) begin nfe[i] = 0; npe[i] = 0; nov[i] = 0; end

    // Pulse-cycle counters; a correct single-cycle pulse adds exactly one per event.
    always @(negedge sampleClk) if (rst_b) begin
        nfe[0] += int'(fe0); npe[0] += int'(pe0); nov[0] += int'(ov0);
        nfe[1] += int'(fe1); npe[1] += int'(pe1); nov[1] += int'(ov1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int w, input logic v);
        if (w == 0) ser0 = v; else ser1 = v;
    endtask
    task automatic set_pop(input int w, input logic v);
        if (w == 0) pop0 = v; else pop1 = v;
    endtask
    function automatic logic get_valid(input int w); return (w == 0) ? valid0 : valid1; endfunction
    function automatic logic get_busy(input int w);  return (w == 0) ? busy0 : busy1;  endfunction
    function automatic logic [W-1:0] get_data(input int w); return (w == 0) ? data0 : data1; endfunction
    function automatic int q_size(input int w); return (w == 0) ? q0.size() : q1.size(); endfunction
    function automatic logic [W-1:0] q_front(input int w); return (w == 0) ? q0[0] : q1[0]; endfunction
    task automatic q_pop(input int w);
        if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endtask
    task automatic q_push(input int w, input logic [W-1:0] d);
        if (w == 0) q0.push_back(d); else q1.push_back(d);
    endtask

    // Drives one frame starting at the next negedge; instance 1 carries an even-parity bit.
    task automatic send_frame(input int w, input logic [W-1:0] d, input logic pbit, input logic stop_v,
                              input bit do_pop, input int glitch, input logic end_lvl,
                              output logic pvalid, output logic [W-1:0] pdata);
        int par, nb, push_cyc;
        logic [15:0] bits;
        logic v;
        par = (w == 1) ? 1 : 0;
        nb = 1 + W + par + 1;
        push_cyc = 7 + OS * (W + par + 1) - 1;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[1+i] = d[i];
        if (par == 1) bits[1+W] = pbit;
        bits[nb-1] = stop_v;
        pvalid = 1'b0;
        pdata = '0;
        for (int c = 0; c < nb * OS; c++) begin
            @(negedge sampleClk);
            v = bits[c/OS];
            if (c == glitch) v = ~v;
            set_line(w, v);
            if (do_pop && c == push_cyc) begin
                set_pop(w, 1'b1);
                pvalid = get_valid(w);
                pdata = get_data(w);
            end else begin
                set_pop(w, 1'b0);
            end
        end
        @(negedge sampleClk);
        set_pop(w, 1'b0);
        set_line(w, end_lvl);
        #1;
    endtask

    task automatic frame(input string tag, input int w, input logic [W-1:0] d, input logic pbit, input logic stop_v,
                         input bit do_pop, input bit e_fe, input bit e_pe, input bit e_push, input int glitch);
        int f0, p0, o0;
        bit e_ov;
        logic pvalid;
        logic [W-1:0] pdata;
        f0 = nfe[w]; p0 = npe[w]; o0 = nov[w];
        send_frame(w, d, pbit, stop_v, do_pop, glitch, 1'b1, pvalid, pdata);
        chk({tag, "_fe"}, nfe[w] - f0, e_fe);
        chk({tag, "_pe"}, npe[w] - p0, e_pe);
        if (do_pop) begin
            chk({tag, "_popvalid"}, pvalid, q_size(w) > 0);
            if (q_size(w) > 0) begin
                chk({tag, "_popdata"}, pdata, q_front(w));
                q_pop(w);
            end
        end
        e_ov = 1'b0;
        if (e_push) begin
            if (q_size(w) < DEPTH) q_push(w, d);
            else e_ov = 1'b1;
        end
        chk({tag, "_ov"}, nov[w] - o0, e_ov);
        chk({tag, "_valid"}, get_valid(w), q_size(w) > 0);
        if (q_size(w) > 0) chk({tag, "_head"}, get_data(w), q_front(w));
        repeat (4) @(negedge sampleClk);
        chk({tag, "_busy"}, get_busy(w), 1'b0);
    endtask

    task automatic drain(input string tag, input int w);
        while (q_size(w) > 0) begin
            @(negedge sampleClk);
            chk({tag, "_dvalid"}, get_valid(w), 1'b1);
            chk({tag, "_ddata"}, get_data(w), q_front(w));
            q_pop(w);
            set_pop(w, 1'b1);
        end
        @(negedge sampleClk);
        set_pop(w, 1'b0);
        chk({tag, "_empty"}, get_valid(w), 1'b0);
    endtask

    typedef struct {
        int w; logic [W-1:0] d; logic pbit; logic stop_v; bit do_pop;
        bit e_fe; bit e_pe; bit e_push;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f0, o0, w;
        bit seen, e_fe, e_pe;
        logic [W-1:0] d;
        logic sv, pb, pv;
        logic [W-1:0] pd;

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge sampleClk);
        chk("rst_valid0", valid0, 1'b0); chk("rst_busy0", busy0, 1'b0); chk("rst_data0", data0, 8'h00);
        chk("rst_err0", {fe0, pe0, ov0}, 3'b000);
        chk("rst_valid1", valid1, 1'b0); chk("rst_busy1", busy1, 1'b0); chk("rst_data1", data1, 8'h00);
        chk("rst_err1", {fe1, pe1, ov1}, 3'b000);
        rst_b = 1'b1;
        repeat (4) @(negedge sampleClk);

        for (int i = 0; i < 8; i++)
            frame($sformatf("tbl%0d", i), tbl[i].w, tbl[i].d, tbl[i].pbit, tbl[i].stop_v, tbl[i].do_pop,
                  tbl[i].e_fe, tbl[i].e_pe, tbl[i].e_push, -1);
        drain("tbl_d0", 0);
        drain("tbl_d1", 1);

        // Two-cycle glitch must be rejected as a false start.
        f0 = nfe[0];
        @(negedge sampleClk); ser0 = 1'b0;
        @(negedge sampleClk);
        @(negedge sampleClk); ser0 = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(negedge sampleClk); seen |= busy0; end
        chk("glitch_started", seen, 1'b1);
        chk("glitch_idle", busy0, 1'b0);
        chk("glitch_nopush", valid0, 1'b0);
        chk("glitch_noerr", nfe[0] - f0 + npe[0], 0);

        // Stuck-low line after a framing error, then recovery.
        f0 = nfe[0];
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0, pv, pd);
        chk("brk_fe", nfe[0] - f0, 1);
        repeat (40) @(negedge sampleClk);
        chk("brk_busy", busy0, 1'b1);
        chk("brk_one_pulse", nfe[0] - f0, 1);
        chk("brk_nopush", valid0, 1'b0);
        ser0 = 1'b1;
        repeat (5) @(negedge sampleClk);
        chk("brk_recover", busy0, 1'b0);
        frame("brk_55", 0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        drain("brk_d", 0);

        // Overrun on a full FIFO, then the same with a pop on the push edge.
        o0 = nov[0];
        for (int i = 0; i < 5; i++)
            frame($sformatf("ovr%0d", i), 0, 8'(8'h11 * (i + 1)), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        chk("ovr_total", nov[0] - o0, 1);
        chk("ovr_q_depth", q0.size(), DEPTH);
        drain("ovr_d", 0);
        o0 = nov[0];
        for (int i = 0; i < 5; i++)
            frame($sformatf("pop%0d", i), 0, 8'(8'hA1 + i), 1'b0, 1'b1, i == 4, 1'b0, 1'b0, 1'b1, -1);
        chk("pop_no_ovr", nov[0] - o0, 0);
        drain("pop_d", 0);

        // Reset in the middle of a data bit.
        frame("rs_pre", 0, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        for (int c = 0; c < 30; c++) begin
            @(negedge sampleClk);
            ser0 = ((c / 8) % 2 == 1);
        end
        chk("rs_busy_before", busy0, 1'b1);
        rst_b = 1'b0;
        #1;
        chk("rs_valid", valid0, 1'b0); chk("rs_data", data0, 8'h00); chk("rs_busy", busy0, 1'b0);
        q0.delete(); q1.delete();
        ser0 = 1'b1;
        repeat (3) @(negedge sampleClk);
        rst_b = 1'b1;
        repeat (4) @(negedge sampleClk);
        frame("rs_96", 0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        drain("rs_d", 0);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle inversion aligned with the bit-3 sampling point.
        frame("maj_5A", 0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12 + 8 * 3);
        drain("maj_d", 0);
`endif

        // Random frames against the rule-based model.
        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(1, 0);
            d = 8'($urandom);
            sv = ($urandom_range(7, 0) != 0);
            pb = (^d) ^ ($urandom_range(3, 0) == 0);
            e_fe = !sv;
            e_pe = !e_fe && (w == 1) && (pb != ^d);
            frame($sformatf("rnd%0d", i), w, d, pb, sv, $urandom_range(2, 0) == 0, e_fe, e_pe, !e_fe && !e_pe, -1);
            if ($urandom_range(4, 0) == 0) drain($sformatf("rnd_d%0d", i), w);
        end
        drain("rnd_end0", 0);
        drain("rnd_end1", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
